// File: rtl/rd_frame_buf.sv
`timescale 1ns / 1ps
// rd_frame_buf: line buffer of the video read path.
//
// True dual-port synchronous RAM on a single clock. Port a is the DDR-side
// write port; port b is the video-side read port. Both ports can read and
// write. The read path is read-first on both ports and across ports.
// When both ports write the same address in the same cycle, port a wins.
// The RAM holds no pointer, wrap or fill state; the caller owns the ring
// pointers.
//
// Ports:
//   clk        shared clock, rising edge
//   rst        async active-high reset; clears both read-data registers
//   a_wr_data  port a write data
//   a_addr     port a address
//   a_wr_en    port a write enable
//   a_rd_data  port a registered read data (1-cycle latency)
//   b_wr_data  port b write data (tied 0 in the read path)
//   b_addr     port b address
//   b_wr_en    port b write enable (tied 0 in the read path)
//   b_rd_data  port b registered read data (1-cycle latency)
module rd_frame_buf #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] a_wr_data,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic                  a_wr_en,
    output logic [DATA_WIDTH-1:0] a_rd_data,
    input  logic [DATA_WIDTH-1:0] b_wr_data,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic                  b_wr_en,
    output logic [DATA_WIDTH-1:0] b_rd_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic b_wr_ok;

    // Port a has priority: a port b write to the address port a is
    // writing in the same cycle is dropped.
    always_comb begin
        b_wr_ok = b_wr_en & ~(a_wr_en & (a_addr == b_addr));
    end

    // Memory contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (a_wr_en) begin
            mem[a_addr] <= a_wr_data;
        end
        if (b_wr_ok) begin
            mem[b_addr] <= b_wr_data;
        end
    end

    // Non-blocking reads sample the pre-write contents, which gives
    // read-first behaviour on both ports, including cross-port collisions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rd_data <= '0;
        end else begin
            a_rd_data <= mem[a_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_rd_data <= '0;
        end else begin
            b_rd_data <= mem[b_addr];
        end
    end

endmodule

// File: tb/tb_rd_frame_buf.sv
`timescale 1ns / 1ps
// Directed self-checking bench for rd_frame_buf.
module tb_rd_frame_buf;

    localparam int unsigned DW = 128;
    localparam int unsigned AW = 10;
    localparam int unsigned DEPTH = 1024;

    logic          clk;
    logic          rst;
    logic [DW-1:0] a_wr_data;
    logic [AW-1:0] a_addr;
    logic          a_wr_en;
    logic [DW-1:0] a_rd_data;
    logic [DW-1:0] b_wr_data;
    logic [AW-1:0] b_addr;
    logic          b_wr_en;
    logic [DW-1:0] b_rd_data;

    logic [DW-1:0] model [DEPTH];

    int n_vec;
    int n_mis;

    rd_frame_buf #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a_wr_data(a_wr_data),
        .a_addr   (a_addr),
        .a_wr_en  (a_wr_en),
        .a_rd_data(a_rd_data),
        .b_wr_data(b_wr_data),
        .b_addr   (b_addr),
        .b_wr_en  (b_wr_en),
        .b_rd_data(b_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_a(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        a_addr    = addr;
        a_wr_data = data;
        a_wr_en   = 1'b1;
        cycle();
        a_wr_en   = 1'b0;
        model[addr] = data;
    endtask

    task automatic rd_b(input string tag, input logic [AW-1:0] addr);
        b_addr = addr;
        cycle();
        check(tag, b_rd_data, model[addr]);
    endtask

    logic [DW-1:0] pat_a;
    logic [15:0]   k16;

    initial begin
        n_vec     = 0;
        n_mis     = 0;
        rst       = 1'b1;
        a_wr_data = '0;
        a_addr    = '0;
        a_wr_en   = 1'b0;
        b_wr_data = '0;
        b_addr    = '0;
        b_wr_en   = 1'b0;
        pat_a     = {32{4'hA}};

        // Reset state.
        cycle();
        cycle();
        check("reset_a", a_rd_data, '0);
        check("reset_b", b_rd_data, '0);
        rst = 1'b0;

        // Async reset while b_rd_data is nonzero.
        wr_a(10'd5, pat_a);
        rd_b("pre_reset_b", 10'd5);
        a_addr = 10'd5;
        cycle();
        check("pre_reset_a", a_rd_data, pat_a);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_a", a_rd_data, '0);
        check("async_reset_b", b_rd_data, '0);
        cycle();
        cycle();
        check("held_reset_a", a_rd_data, '0);
        check("held_reset_b", b_rd_data, '0);
        rst = 1'b0;
        b_addr = 10'd5;
        cycle();
        check("post_reset_b", b_rd_data, pat_a);

        // Streaming write on a, then back-to-back reads on b.
        for (int k = 0; k < DEPTH; k++) begin
            k16 = 16'(k);
            a_addr    = AW'(k);
            a_wr_data = {8{k16}};
            a_wr_en   = 1'b1;
            model[k]  = {8{k16}};
            cycle();
        end
        a_wr_en = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            k16 = 16'(k);
            b_addr = AW'(k);
            cycle();
            check("stream_rd", b_rd_data, {8{k16}});
        end

        // Ring wrap: 1023 then 0.
        wr_a(10'd1023, 128'h1);
        wr_a(10'd0, 128'h2);
        b_addr = 10'd1023;
        cycle();
        check("wrap_1023", b_rd_data, 128'h1);
        b_addr = 10'd0;
        cycle();
        check("wrap_0", b_rd_data, 128'h2);

        // Cross-port collision is read-first.
        wr_a(10'd7, 128'h11);
        a_addr    = 10'd7;
        a_wr_data = 128'h22;
        a_wr_en   = 1'b1;
        b_addr    = 10'd7;
        cycle();
        a_wr_en   = 1'b0;
        model[7]  = 128'h22;
        check("xport_old", b_rd_data, 128'h11);
        cycle();
        check("xport_new", b_rd_data, 128'h22);

        // Same-port read-first.
        wr_a(10'd9, 128'h44);
        a_addr    = 10'd9;
        a_wr_data = 128'h33;
        a_wr_en   = 1'b1;
        b_addr    = 10'd9;
        cycle();
        check("rdfirst_a", a_rd_data, 128'h44);
        check("rdfirst_b", b_rd_data, 128'h44);

        // Dual write to the same address: a wins, both read old data.
        a_wr_data = 128'h55;
        b_wr_data = 128'h66;
        b_wr_en   = 1'b1;
        cycle();
        a_wr_en   = 1'b0;
        b_wr_en   = 1'b0;
        model[9]  = 128'h55;
        check("dual_old_a", a_rd_data, 128'h33);
        check("dual_old_b", b_rd_data, 128'h33);
        cycle();
        check("dual_win_a", a_rd_data, 128'h55);
        check("dual_win_b", b_rd_data, 128'h55);

        // Plain port b write, read back on a.
        b_addr    = 10'd12;
        b_wr_data = 128'h77;
        b_wr_en   = 1'b1;
        cycle();
        b_wr_en   = 1'b0;
        model[12] = 128'h77;
        a_addr    = 10'd12;
        cycle();
        check("b_write", a_rd_data, 128'h77);

        // Enables low with random data and addresses.
        for (int i = 0; i < 100; i++) begin
            a_wr_data = {$urandom, $urandom, $urandom, $urandom};
            b_wr_data = {$urandom, $urandom, $urandom, $urandom};
            a_addr    = AW'($urandom_range(0, DEPTH - 1));
            b_addr    = AW'($urandom_range(0, DEPTH - 1));
            cycle();
            check("idle_rd_a", a_rd_data, model[a_addr]);
            check("idle_rd_b", b_rd_data, model[b_addr]);
        end

        // Full readback on both ports, opposite directions.
        for (int k = 0; k < DEPTH; k++) begin
            a_addr = AW'(DEPTH - 1 - k);
            b_addr = AW'(k);
            cycle();
            check("full_rd_a", a_rd_data, model[DEPTH - 1 - k]);
            check("full_rd_b", b_rd_data, model[k]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
